register_file_sb: RTL and testbench
===================================

REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 4, meaning register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 4, meaning register count (2..64).
REQ-003 SHALL have derived localparam ADDR_W = max(1, clog2(NUM_REGS)), meaning address width.
REQ-004 SHALL have parameter BYPASS, default 1, meaning same-cycle write-to-read forwarding (0/1).
REQ-005 SHALL have parameter RD_LAT, default 0, meaning read latency in cycles (0 or 1).
REQ-006 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have ports rd_addr1, rd_addr2  input  ADDR_W  read-port select.
REQ-009 SHALL have ports rd_data1, rd_data2  output  DATA_W  read-port data.
REQ-010 SHALL have ports rd_busy1, rd_busy2  output  1  busy flag of the selected register.
REQ-011 SHALL have ports wr_en (input, 1), wr_addr (input, ADDR_W) and wr_data (input, DATA_W) for write-back.
REQ-012 SHALL have ports rsv_en (input, 1) and rsv_addr (input, ADDR_W) for destination reservation requests.
REQ-013 SHALL have port rsv_ok  output  1  combinational: reservation accepted this cycle.
REQ-014 SHALL have port busy_vec  output  NUM_REGS  per-register busy bits, bit i = register i.

Function
REQ-015 SHALL write wr_data into register wr_addr on the rising edge when wr_en=1 and wr_addr<NUM_REGS; out-of-range writes are ignored.
REQ-016 SHALL clear busy[wr_addr] on every accepted write, whether or not it was reserved.
REQ-017 SHALL assert rsv_ok = rsv_en & (rsv_addr<NUM_REGS) & ~busy[rsv_addr], using pre-edge busy state.
REQ-018 SHALL set busy[rsv_addr] on the edge where rsv_ok=1; rejected requests change no state.
REQ-019 SHALL, for a write and an accepted reservation to the same register in one cycle, store the data and leave busy=1; if the register was already busy, the reservation is rejected and busy=0 after the edge.
REQ-020 SHALL with RD_LAT=0 drive rd_data/rd_busy combinationally from rd_addr.
REQ-021 SHALL with RD_LAT=0 and BYPASS=1, when wr_en=1 and wr_addr equals a read address, return wr_data and busy=0 on that port in the same cycle.
REQ-022 SHALL with RD_LAT=1 register rd_data/rd_busy at the edge, reflecting the post-edge state (write-first), independent of BYPASS.
REQ-023 SHALL return data 0 and busy 0 for out-of-range read addresses.
REQ-024 SHALL support any combination of read-port addresses, including both ports on one register.

Reset
REQ-025 SHALL on reset=1 immediately set register i to i mod 2^DATA_W, all busy bits to 0, and registered read outputs (RD_LAT=1) to 0.
REQ-026 SHALL, when reset is asserted mid-operation, discard any same-edge write or reservation.
REQ-027 SHALL resume normal operation on the first rising edge after reset deasserts.

Structure
REQ-028 SHALL place default DATA_W/NUM_REGS, the ADDR_W derivation and the reset-value function in shared package regfile_pkg.
REQ-029 SHALL implement busy tracking (REQ-016..019) in one sub-module, reg_scoreboard; data storage and read muxing stay in the top.
REQ-030 SHALL implement read selection as an indexed array access, not a per-combination case table.

Verification
REQ-031 SHALL cover reset with defaults: reads of reg0..reg3 -> 0,1,2,3; busy_vec=4'b0000.
REQ-032 SHALL cover reserve/write: rsv reg2 -> rsv_ok=1, busy_vec=4'b0100; second rsv reg2 -> rsv_ok=0; write 4'hA to reg2 -> busy_vec=0, read reg2=A.
REQ-033 SHALL cover bypass (RD_LAT=0, BYPASS=1): wr reg1=4'h7 with rd_addr1=rd_addr2=1 -> both 7 and busy 0 that cycle.
REQ-034 SHALL cover same-cycle write and reservation of free reg3 -> data stored, busy[3]=1; repeat while busy -> rsv_ok=0, busy[3]=0.
REQ-035 SHALL cover RD_LAT=1, DATA_W=8, NUM_REGS=6: wr reg5=8'h5A -> rd_data1=5A one edge later; read addr 7 -> 0.
REQ-036 SHALL cover async reset asserted between edges while reg0 and reg1 are busy -> immediate busy_vec=0, reg0=0, no pending write lands.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
// Holds the address-width derivation and the per-register reset value.
package regfile_pkg;

  localparam int DEFAULT_DATA_W   = 4;
  localparam int DEFAULT_NUM_REGS = 4;

  // A single register still needs one address bit.
  function automatic int addr_width(input int num_regs);
    return (num_regs > 2) ? $clog2(num_regs) : 1;
  endfunction

  // Register i comes out of reset holding i truncated to the register width.
  function automatic longint unsigned reset_value(input int idx, input int width);
    if (width >= 31) return longint'(idx);
    return longint'(idx % (1 << width));
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit tracker: reservations set a register busy, write-backs clear it.
// A reservation is only granted against the busy state before the edge.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = addr_width(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                rsv_en,
  input  logic [ADDR_W-1:0]   rsv_addr,
  output logic                rsv_ok,
  output logic [NUM_REGS-1:0] busy_vec
);

  localparam logic [ADDR_W:0] NUM_REGS_C = NUM_REGS[ADDR_W:0];

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                wr_hit;
  logic                rsv_in_range;

  assign wr_hit       = wr_en & ({1'b0, wr_addr} < NUM_REGS_C);
  assign rsv_in_range = {1'b0, rsv_addr} < NUM_REGS_C;
  assign rsv_ok       = rsv_en & rsv_in_range & ~busy_q[rsv_addr];

  // Set after clear, so a write plus a granted reservation leaves the register busy.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_hit && (wr_addr == ADDR_W'(i))) busy_d[i] = 1'b0;
      if (rsv_ok && (rsv_addr == ADDR_W'(i))) busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/register_file_sb.sv
// Register file with per-register busy scoreboard, two read ports and one write port.
// Read ports are either combinational (optional write bypass) or registered write-first.
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int  DATA_W   = DEFAULT_DATA_W,
  parameter int  NUM_REGS = DEFAULT_NUM_REGS,
  parameter int  BYPASS   = 1,
  parameter int  RD_LAT   = 0,
  localparam int ADDR_W   = addr_width(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  output logic [DATA_W-1:0]   rd_data1,
  output logic [DATA_W-1:0]   rd_data2,
  output logic                rd_busy1,
  output logic                rd_busy2,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rsv_en,
  input  logic [ADDR_W-1:0]   rsv_addr,
  output logic                rsv_ok,
  output logic [NUM_REGS-1:0] busy_vec
);

  localparam logic [ADDR_W:0] NUM_REGS_C = NUM_REGS[ADDR_W:0];

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              wr_valid;
  logic [ADDR_W-1:0] rd_addr_a [2];

  // A write arriving while reset is held is discarded, so it must not be forwarded either.
  assign wr_valid     = wr_en & ~reset & ({1'b0, wr_addr} < NUM_REGS_C);
  assign rd_addr_a[0] = rd_addr1;
  assign rd_addr_a[1] = rd_addr2;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ok   (rsv_ok),
    .busy_vec (busy_vec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= DATA_W'(reset_value(i, DATA_W));
    end else if (wr_valid) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic              in_range;
    logic [DATA_W-1:0] cur_data;
    logic              cur_busy;
    logic [DATA_W-1:0] data_o;
    logic              busy_o;

    always_comb begin
      in_range = {1'b0, rd_addr_a[p]} < NUM_REGS_C;
      cur_data = '0;
      cur_busy = 1'b0;
      if (in_range) begin
        cur_data = regs_q[rd_addr_a[p]];
        cur_busy = busy_vec[rd_addr_a[p]];
      end
    end

    if (RD_LAT == 0) begin : g_comb
      logic wr_hit;

      always_comb begin
        wr_hit = (BYPASS != 0) & wr_valid & (wr_addr == rd_addr_a[p]);
        data_o = cur_data;
        busy_o = cur_busy;
        if (wr_hit) begin
          data_o = wr_data;
          busy_o = 1'b0;
        end
      end
    end else begin : g_reg
      logic              wr_hit;
      logic              rsv_hit;
      logic [DATA_W-1:0] nxt_data;
      logic              nxt_busy;

      // Post-edge view: the write lands first, then a granted reservation re-marks busy.
      always_comb begin
        wr_hit   = wr_valid & (wr_addr == rd_addr_a[p]);
        rsv_hit  = rsv_ok & (rsv_addr == rd_addr_a[p]);
        nxt_data = wr_hit ? wr_data : cur_data;
        nxt_busy = in_range & (rsv_hit | (~wr_hit & cur_busy));
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          data_o <= '0;
          busy_o <= 1'b0;
        end else begin
          data_o <= nxt_data;
          busy_o <= nxt_busy;
        end
      end
    end
  end

  assign rd_data1 = g_port[0].data_o;
  assign rd_data2 = g_port[1].data_o;
  assign rd_busy1 = g_port[0].busy_o;
  assign rd_busy2 = g_port[1].busy_o;

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: directed scenarios plus randomized traffic
// scored against an array-based reference model through expectation queues.
module tb_register_file_sb;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // dut0: DATA_W=4, NUM_REGS=4, BYPASS=1, RD_LAT=0
  logic [1:0] a_rd1, a_rd2, a_wa, a_ra;
  logic [3:0] a_wd, a_d1, a_d2, a_bv;
  logic       a_we, a_re, a_b1, a_b2, a_ok;

  // dut1: DATA_W=8, NUM_REGS=6, BYPASS=0, RD_LAT=1
  logic [2:0] b_rd1, b_rd2, b_wa, b_ra;
  logic [7:0] b_wd, b_d1, b_d2;
  logic [5:0] b_bv;
  logic       b_we, b_re, b_b1, b_b2, b_ok;

  register_file_sb #(.DATA_W(4), .NUM_REGS(4), .BYPASS(1), .RD_LAT(0)) dut0 (
    .clk(clk), .reset(reset), .rd_addr1(a_rd1), .rd_addr2(a_rd2),
    .rd_data1(a_d1), .rd_data2(a_d2), .rd_busy1(a_b1), .rd_busy2(a_b2),
    .wr_en(a_we), .wr_addr(a_wa), .wr_data(a_wd), .rsv_en(a_re), .rsv_addr(a_ra),
    .rsv_ok(a_ok), .busy_vec(a_bv)
  );

  register_file_sb #(.DATA_W(8), .NUM_REGS(6), .BYPASS(0), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .rd_addr1(b_rd1), .rd_addr2(b_rd2),
    .rd_data1(b_d1), .rd_data2(b_d2), .rd_busy1(b_b1), .rd_busy2(b_b2),
    .wr_en(b_we), .wr_addr(b_wa), .wr_data(b_wd), .rsv_en(b_re), .rsv_addr(b_ra),
    .rsv_ok(b_ok), .busy_vec(b_bv)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] d1, d2, bv;
    logic       b1, b2, ok;
  } exp0_t;

  typedef struct {
    logic [7:0] d1, d2;
    logic [5:0] bv;
    logic       b1, b2;
  } exp1_t;

  exp0_t q0[$];
  exp1_t q1[$];

  // Reference state: contents and busy flags per register.
  logic [3:0] m0 [4];
  logic       bz0 [4];
  logic [7:0] m1 [6];
  logic       bz1 [6];

  // Combinational-port monitor: compares in the low half of the cycle.
  initial forever begin
    @(negedge clk);
    #2;
    if (q0.size() > 0) begin
      exp0_t e;
      e = q0.pop_front();
      check("sb0_rd_data1", a_d1, e.d1);
      check("sb0_rd_data2", a_d2, e.d2);
      check("sb0_rd_busy1", a_b1, e.b1);
      check("sb0_rd_busy2", a_b2, e.b2);
      check("sb0_rsv_ok", a_ok, e.ok);
      check("sb0_busy_vec", a_bv, e.bv);
    end
  end

  // Registered-port monitor: compares just after the edge that loaded the outputs.
  initial forever begin
    @(posedge clk);
    #1;
    if (q1.size() > 0) begin
      exp1_t e;
      e = q1.pop_front();
      check("sb1_rd_data1", b_d1, e.d1);
      check("sb1_rd_data2", b_d2, e.d2);
      check("sb1_rd_busy1", b_b1, e.b1);
      check("sb1_rd_busy2", b_b2, e.b2);
      check("sb1_busy_vec", b_bv, e.bv);
    end
  end

  task automatic idle_inputs();
    a_we = 0; a_wa = 0; a_wd = 0; a_re = 0; a_ra = 0; a_rd1 = 0; a_rd2 = 0;
    b_we = 0; b_wa = 0; b_wd = 0; b_re = 0; b_ra = 0; b_rd1 = 0; b_rd2 = 0;
  endtask

  initial begin
    exp0_t e0;
    exp1_t e1;
    logic  ok1;

    reset = 1'b1;
    idle_inputs();
    #1;
    check("reset_busy_vec", a_bv, 4'b0000);
    check("reset_rd_lat1_data", b_d1, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset contents of the default configuration.
    for (int i = 0; i < 4; i++) begin
      a_rd1 = 2'(i);
      a_rd2 = 2'(3 - i);
      #1;
      check("reset_rd1", a_d1, 4'(i));
      check("reset_rd2", a_d2, 4'(3 - i));
    end

    // Reserve reg2, re-request while busy, then write it back.
    @(negedge clk);
    a_re = 1; a_ra = 2;
    #2 check("rsv2_ok", a_ok, 1);
    @(posedge clk); #1;
    check("rsv2_busy_vec", a_bv, 4'b0100);
    check("rsv2_again_ok", a_ok, 0);
    @(negedge clk);
    a_re = 0; a_we = 1; a_wa = 2; a_wd = 4'hA; a_rd1 = 2;
    @(negedge clk);
    a_we = 0;
    #2;
    check("wr2_busy_vec", a_bv, 4'b0000);
    check("wr2_rd_data", a_d1, 4'hA);

    // Bypass onto both ports for a busy register.
    @(negedge clk);
    a_re = 1; a_ra = 1;
    @(negedge clk);
    a_re = 0; a_we = 1; a_wa = 1; a_wd = 4'h7; a_rd1 = 1; a_rd2 = 1;
    #2;
    check("byp_rd_data1", a_d1, 4'h7);
    check("byp_rd_data2", a_d2, 4'h7);
    check("byp_rd_busy1", a_b1, 0);
    check("byp_rd_busy2", a_b2, 0);
    @(negedge clk);
    a_we = 0;
    #2 check("byp_stored", a_d1, 4'h7);

    // Same-cycle write and reservation: free register, then already-busy register.
    @(negedge clk);
    a_we = 1; a_wa = 3; a_wd = 4'h5; a_re = 1; a_ra = 3; a_rd1 = 3;
    #2 check("wr_rsv3_ok", a_ok, 1);
    @(negedge clk);
    a_we = 0; a_re = 0;
    #2;
    check("wr_rsv3_busy", a_bv[3], 1);
    check("wr_rsv3_data", a_d1, 4'h5);
    @(negedge clk);
    a_we = 1; a_wd = 4'h9; a_re = 1;
    #2 check("wr_rsv3_busy_ok", a_ok, 0);
    @(negedge clk);
    a_we = 0; a_re = 0;
    #2;
    check("wr_rsv3_busy_clr", a_bv[3], 0);
    check("wr_rsv3_data2", a_d1, 4'h9);

    // Registered read port on the 8-bit, 6-register instance.
    @(negedge clk);
    b_we = 1; b_wa = 5; b_wd = 8'h5A; b_rd1 = 5; b_rd2 = 7;
    @(posedge clk); #1;
    check("lat1_rd_data1", b_d1, 8'h5A);
    check("lat1_oob_data", b_d2, 8'h00);
    check("lat1_oob_busy", b_b2, 0);
    @(negedge clk);
    b_we = 0;

    // Asynchronous reset between edges while reg0/reg1 are busy and a write is pending.
    @(negedge clk);
    a_re = 1; a_ra = 0;
    @(negedge clk);
    a_ra = 1;
    @(negedge clk);
    a_re = 0;
    #2 check("pre_rst_busy_vec", a_bv, 4'b0011);
    @(negedge clk);
    a_we = 1; a_wa = 0; a_wd = 4'hF; a_rd1 = 0; a_rd2 = 1;
    #2 reset = 1'b1;
    #1;
    check("async_rst_busy_vec", a_bv, 4'b0000);
    check("async_rst_rd0", a_d1, 4'h0);
    check("async_rst_rd1", a_d2, 4'h1);
    check("async_rst_lat1", b_d1, 8'h00);
    @(posedge clk); #1;
    check("rst_hold_rd0", a_d1, 4'h0);
    @(negedge clk);
    a_we = 0;
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_rd0", a_d1, 4'h0);
    check("post_rst_busy_vec", a_bv, 4'b0000);

    // Randomized traffic from a fresh reset, scored through the queues.
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin m0[i] = 4'(i); bz0[i] = 0; end
    for (int i = 0; i < 6; i++) begin m1[i] = 8'(i); bz1[i] = 0; end

    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      a_we  = 1'($urandom_range(0, 1));
      a_wa  = 2'($urandom_range(0, 3));
      a_wd  = 4'($urandom_range(0, 15));
      a_re  = 1'($urandom_range(0, 1));
      a_ra  = 2'($urandom_range(0, 3));
      a_rd1 = 2'($urandom_range(0, 3));
      a_rd2 = 2'($urandom_range(0, 3));
      b_we  = 1'($urandom_range(0, 1));
      b_wa  = 3'($urandom_range(0, 7));
      b_wd  = 8'($urandom_range(0, 255));
      b_re  = 1'($urandom_range(0, 1));
      b_ra  = 3'($urandom_range(0, 7));
      b_rd1 = 3'($urandom_range(0, 7));
      b_rd2 = 3'($urandom_range(0, 7));

      e0.ok = a_re && !bz0[a_ra];
      for (int i = 0; i < 4; i++) e0.bv[i] = bz0[i];
      if (a_we && a_wa == a_rd1) begin e0.d1 = a_wd; e0.b1 = 0; end
      else begin e0.d1 = m0[a_rd1]; e0.b1 = bz0[a_rd1]; end
      if (a_we && a_wa == a_rd2) begin e0.d2 = a_wd; e0.b2 = 0; end
      else begin e0.d2 = m0[a_rd2]; e0.b2 = bz0[a_rd2]; end
      q0.push_back(e0);
      if (a_we) begin m0[a_wa] = a_wd; bz0[a_wa] = 0; end
      if (e0.ok) bz0[a_ra] = 1;

      ok1 = b_re && (b_ra < 6) && !bz1[b_ra];
      if (b_we && b_wa < 6) begin m1[b_wa] = b_wd; bz1[b_wa] = 0; end
      if (ok1) bz1[b_ra] = 1;
      e1.d1 = (b_rd1 < 6) ? m1[b_rd1] : 8'h00;
      e1.b1 = (b_rd1 < 6) ? bz1[b_rd1] : 1'b0;
      e1.d2 = (b_rd2 < 6) ? m1[b_rd2] : 8'h00;
      e1.b2 = (b_rd2 < 6) ? bz1[b_rd2] : 1'b0;
      for (int i = 0; i < 6; i++) e1.bv[i] = bz1[i];
      q1.push_back(e1);
    end

    @(negedge clk);
    idle_inputs();
    repeat (2) @(posedge clk);
    #3;
    check("sb_drain", 64'(q0.size() + q1.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
